// File: rtl/sfr_bus_master.sv
// ---------------------------------------------------------------------------
// sfr_bus_master
//
// Initiator side of the SFR register-file bus. Takes one access request at a
// time from CPU control and sequences it onto the SFR bus. The supported
// requests are byte read, byte write, bit read, bit write, read-modify-write
// (ANL/ORL/XRL) and bit complement. The result comes back to CPU control as a
// single-cycle response pulse.
//
// Parameters
//   RD_LATENCY          posedges from a stable sfr_addr_o to valid sfr_rdata_i
//                       (1..3)
//
// Ports
//   clock_i             system clock
//   reset_i             synchronous, active-high reset
//   req_valid_i         request present
//   req_ready_o         block can accept a request (high only when idle)
//   req_op_i            0 RD, 1 WR, 2 BRD, 3 BWR, 4 ANL, 5 ORL, 6 XRL, 7 CPLB
//   req_addr_i          SFR byte address or bit address, depending on op
//   req_data_i          write data / read-modify-write operand
//   req_bit_i           bit value for BWR
//   rsp_valid_o         one-cycle response pulse
//   rsp_data_o          read byte (RD/BRD), written byte (WR/ANL/ORL/XRL)
//   rsp_bit_o           selected bit (BRD), new bit (CPLB), written bit (BWR)
//   rsp_err_o           request rejected (address outside SFR space)
//   sfr_addr_o          address to register file
//   sfr_wdata_o         byte write data
//   sfr_bit_o           bit write data
//   sfr_write_en_o      byte write strobe
//   sfr_write_bit_en_o  bit write strobe
//   sfr_rdata_i         registered read data from register file
// ---------------------------------------------------------------------------
module sfr_bus_master #(
    parameter int RD_LATENCY = 1
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [2:0] req_op_i,
    input  logic [7:0] req_addr_i,
    input  logic [7:0] req_data_i,
    input  logic       req_bit_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    output logic       rsp_bit_o,
    output logic       rsp_err_o,
    output logic [7:0] sfr_addr_o,
    output logic [7:0] sfr_wdata_o,
    output logic       sfr_bit_o,
    output logic       sfr_write_en_o,
    output logic       sfr_write_bit_en_o,
    input  logic [7:0] sfr_rdata_i
);

    typedef enum logic [2:0] {
        OP_RD   = 3'd0,
        OP_WR   = 3'd1,
        OP_BRD  = 3'd2,
        OP_BWR  = 3'd3,
        OP_ANL  = 3'd4,
        OP_ORL  = 3'd5,
        OP_XRL  = 3'd6,
        OP_CPLB = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_WAIT   = 3'd2,
        S_MODIFY = 3'd3,
        S_WRITE  = 3'd4,
        S_RESP   = 3'd5
    } state_e;

    // The read phase lasts RD_LATENCY cycles. The counter is loaded with
    // RD_LATENCY-1 and read data is sampled when it reaches zero.
    localparam logic [1:0] LatReload = 2'(RD_LATENCY - 1);

    state_e     state_q;
    op_e        op_q;
    logic [7:0] addr_q;
    logic [7:0] data_q;
    logic       reqBit_q;
    logic [7:0] rdata_q;
    logic [1:0] latCnt_q;

    logic       reqReady_q;
    logic       rspValid_q;
    logic [7:0] rspData_q;
    logic       rspBit_q;
    logic       rspErr_q;
    logic [7:0] sfrAddr_q;
    logic [7:0] sfrWdata_q;
    logic       sfrBit_q;
    logic       sfrWriteEn_q;
    logic       sfrWriteBitEn_q;

    logic       accept;
    op_e        reqOp;
    logic [7:0] reqByteAddr;
    logic [7:0] newByte_d;
    logic       newBit_d;

    assign accept      = req_valid_i && reqReady_q;
    assign reqOp       = op_e'(req_op_i);
    // Bit addresses select byte {addr[7:3],000}; addr[2:0] is the bit index.
    assign reqByteAddr = {req_addr_i[7:3], 3'b000};

    // Modify-phase results are computed from the byte captured at the end of
    // the read phase and the operand captured at acceptance.
    always_comb begin
        newByte_d = rdata_q;
        unique case (op_q)
            OP_ANL:  newByte_d = rdata_q & data_q;
            OP_ORL:  newByte_d = rdata_q | data_q;
            OP_XRL:  newByte_d = rdata_q ^ data_q;
            default: newByte_d = rdata_q;
        endcase
        newBit_d = ~rdata_q[addr_q[2:0]];
    end

    // Single sequencing FSM. Every output is a register. The strobes and
    // rsp_valid default low each cycle, so each one is a pulse lasting one
    // cycle. Address and write data are left untouched so they persist
    // while the FSM is idle.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q         <= S_IDLE;
            op_q            <= OP_RD;
            addr_q          <= '0;
            data_q          <= '0;
            reqBit_q        <= 1'b0;
            rdata_q         <= '0;
            latCnt_q        <= '0;
            reqReady_q      <= 1'b1;
            rspValid_q      <= 1'b0;
            rspData_q       <= '0;
            rspBit_q        <= 1'b0;
            rspErr_q        <= 1'b0;
            sfrAddr_q       <= '0;
            sfrWdata_q      <= '0;
            sfrBit_q        <= 1'b0;
            sfrWriteEn_q    <= 1'b0;
            sfrWriteBitEn_q <= 1'b0;
        end else begin
            rspValid_q      <= 1'b0;
            sfrWriteEn_q    <= 1'b0;
            sfrWriteBitEn_q <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q       <= reqOp;
                        addr_q     <= req_addr_i;
                        data_q     <= req_data_i;
                        reqBit_q   <= req_bit_i;
                        reqReady_q <= 1'b0;
                        if (!req_addr_i[7]) begin
                            // Outside SFR space: reject without touching the bus.
                            state_q    <= S_RESP;
                            rspValid_q <= 1'b1;
                            rspErr_q   <= 1'b1;
                            rspData_q  <= '0;
                            rspBit_q   <= 1'b0;
                        end else begin
                            unique case (reqOp)
                                OP_WR: begin
                                    state_q      <= S_WRITE;
                                    sfrAddr_q    <= req_addr_i;
                                    sfrWdata_q   <= req_data_i;
                                    sfrWriteEn_q <= 1'b1;
                                end
                                OP_BWR: begin
                                    state_q         <= S_WRITE;
                                    sfrAddr_q       <= req_addr_i;
                                    sfrBit_q        <= req_bit_i;
                                    sfrWriteBitEn_q <= 1'b1;
                                end
                                OP_BRD, OP_CPLB: begin
                                    state_q   <= S_ADDR;
                                    sfrAddr_q <= reqByteAddr;
                                    latCnt_q  <= LatReload;
                                end
                                default: begin
                                    state_q   <= S_ADDR;
                                    sfrAddr_q <= req_addr_i;
                                    latCnt_q  <= LatReload;
                                end
                            endcase
                        end
                    end
                end

                S_ADDR, S_WAIT: begin
                    if (latCnt_q == 2'd0) begin
                        rdata_q <= sfr_rdata_i;
                        if (op_q == OP_RD || op_q == OP_BRD) begin
                            state_q    <= S_RESP;
                            rspValid_q <= 1'b1;
                            rspErr_q   <= 1'b0;
                            rspData_q  <= sfr_rdata_i;
                            rspBit_q   <= (op_q == OP_BRD) ? sfr_rdata_i[addr_q[2:0]] : 1'b0;
                        end else begin
                            state_q <= S_MODIFY;
                        end
                    end else begin
                        latCnt_q <= latCnt_q - 2'd1;
                        state_q  <= S_WAIT;
                    end
                end

                // CPLB reads the containing byte but writes through the bit
                // port. For that op alone the address switches to the full
                // bit address for its write cycle.
                S_MODIFY: begin
                    state_q <= S_WRITE;
                    if (op_q == OP_CPLB) begin
                        sfrAddr_q       <= addr_q;
                        sfrBit_q        <= newBit_d;
                        sfrWriteBitEn_q <= 1'b1;
                    end else begin
                        sfrWdata_q   <= newByte_d;
                        sfrWriteEn_q <= 1'b1;
                    end
                end

                S_WRITE: begin
                    state_q    <= S_RESP;
                    rspValid_q <= 1'b1;
                    rspErr_q   <= 1'b0;
                    unique case (op_q)
                        OP_WR: begin
                            rspData_q <= data_q;
                            rspBit_q  <= 1'b0;
                        end
                        OP_BWR: begin
                            rspData_q <= '0;
                            rspBit_q  <= reqBit_q;
                        end
                        OP_CPLB: begin
                            rspData_q <= '0;
                            rspBit_q  <= sfrBit_q;
                        end
                        default: begin
                            rspData_q <= sfrWdata_q;
                            rspBit_q  <= 1'b0;
                        end
                    endcase
                end

                S_RESP: begin
                    state_q    <= S_IDLE;
                    reqReady_q <= 1'b1;
                end

                default: begin
                    state_q    <= S_IDLE;
                    reqReady_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o        = reqReady_q;
    assign rsp_valid_o        = rspValid_q;
    assign rsp_data_o         = rspData_q;
    assign rsp_bit_o          = rspBit_q;
    assign rsp_err_o          = rspErr_q;
    assign sfr_addr_o         = sfrAddr_q;
    assign sfr_wdata_o        = sfrWdata_q;
    assign sfr_bit_o          = sfrBit_q;
    assign sfr_write_en_o     = sfrWriteEn_q;
    assign sfr_write_bit_en_o = sfrWriteBitEn_q;

endmodule

// File: tb/tb_sfr_bus_master.sv
// ---------------------------------------------------------------------------
// tb_sfr_bus_master
//
// Scoreboard bench for sfr_bus_master. The main instance uses RD_LATENCY=1 and
// sits on a behavioural register file. Every issued request is applied to a
// byte-array reference model. The expected response and the expected bus
// write are queued, and a monitor pops and compares them as the DUT presents
// them. A second instance with RD_LATENCY=2 covers the longer read timing and
// a reset that arrives in the middle of an XRL.
// ---------------------------------------------------------------------------
module tb_sfr_bus_master;

    localparam int LAT = 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       reqValid;
    logic       reqReady;
    logic [2:0] reqOp;
    logic [7:0] reqAddr;
    logic [7:0] reqData;
    logic       reqBit;
    logic       rspValid;
    logic [7:0] rspData;
    logic       rspBit;
    logic       rspErr;
    logic [7:0] sfrAddr;
    logic [7:0] sfrWdata;
    logic       sfrBit;
    logic       sfrWriteEn;
    logic       sfrWriteBitEn;
    logic [7:0] sfrRdata;

    logic       reset2;
    logic       reqValid2;
    logic       reqReady2;
    logic [2:0] reqOp2;
    logic [7:0] reqAddr2;
    logic [7:0] reqData2;
    logic       rspValid2;
    logic [7:0] rspData2;
    logic       rspBit2;
    logic       rspErr2;
    logic [7:0] sfrAddr2;
    logic [7:0] sfrWdata2;
    logic       sfrBit2;
    logic       sfrWriteEn2;
    logic       sfrWriteBitEn2;
    logic [7:0] sfrRdata2;
    logic [7:0] rdStage2;

    logic       preEn;
    logic [7:0] preAddr;
    logic [7:0] preVal;

    int cyc    = 0;
    int checks = 0;
    int fails  = 0;

    typedef struct {
        int         due;
        logic [2:0] op;
        logic       err;
        logic       chkData;
        logic [7:0] data;
        logic       chkBit;
        logic       bitv;
        logic       chkAddr;
        logic [7:0] addr;
    } rsp_t;

    typedef struct {
        logic       isBit;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       bitv;
    } wr_t;

    rsp_t rspQ[$];
    wr_t  wrQ[$];
    rsp_t monR;
    wr_t  monW;

    logic [7:0] model[256];
    logic [7:0] regs[256];
    logic [7:0] regs2[256];

    sfr_bus_master #(.RD_LATENCY(LAT)) dut (
        .clock_i(clock), .reset_i(reset),
        .req_valid_i(reqValid), .req_ready_o(reqReady), .req_op_i(reqOp),
        .req_addr_i(reqAddr), .req_data_i(reqData), .req_bit_i(reqBit),
        .rsp_valid_o(rspValid), .rsp_data_o(rspData), .rsp_bit_o(rspBit), .rsp_err_o(rspErr),
        .sfr_addr_o(sfrAddr), .sfr_wdata_o(sfrWdata), .sfr_bit_o(sfrBit),
        .sfr_write_en_o(sfrWriteEn), .sfr_write_bit_en_o(sfrWriteBitEn),
        .sfr_rdata_i(sfrRdata)
    );

    sfr_bus_master #(.RD_LATENCY(2)) dut2 (
        .clock_i(clock), .reset_i(reset2),
        .req_valid_i(reqValid2), .req_ready_o(reqReady2), .req_op_i(reqOp2),
        .req_addr_i(reqAddr2), .req_data_i(reqData2), .req_bit_i(1'b0),
        .rsp_valid_o(rspValid2), .rsp_data_o(rspData2), .rsp_bit_o(rspBit2), .rsp_err_o(rspErr2),
        .sfr_addr_o(sfrAddr2), .sfr_wdata_o(sfrWdata2), .sfr_bit_o(sfrBit2),
        .sfr_write_en_o(sfrWriteEn2), .sfr_write_bit_en_o(sfrWriteBitEn2),
        .sfr_rdata_i(sfrRdata2)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Register files. The DUT address is already a register output, so a
    // direct lookup gives data one posedge after the address settles. The
    // second file adds one stage for RD_LATENCY=2.
    always @(posedge clock) begin
        if (preEn) begin
            regs[preAddr]  <= preVal;
            regs2[preAddr] <= preVal;
        end else begin
            if (sfrWriteEn)     regs[sfrAddr] <= sfrWdata;
            if (sfrWriteBitEn)  regs[{sfrAddr[7:3], 3'b000}][sfrAddr[2:0]] <= sfrBit;
            if (sfrWriteEn2)    regs2[sfrAddr2] <= sfrWdata2;
            if (sfrWriteBitEn2) regs2[{sfrAddr2[7:3], 3'b000}][sfrAddr2[2:0]] <= sfrBit2;
        end
        rdStage2 <= regs2[sfrAddr2];
    end

    assign sfrRdata  = regs[sfrAddr];
    assign sfrRdata2 = rdStage2;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one request. Then apply its effect to the reference model and
    // queue the response and any bus write it must produce.
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] addr,
                                 input logic [7:0] data, input logic b, input logic hold);
        int budget = 0;
        int lat;
        int acc;
        rsp_t e;
        wr_t w;
        logic [7:0] byteA;
        logic [2:0] idx;
        logic [7:0] nv;
        logic nb;
        @(negedge clock);
        reqValid = 1'b1; reqOp = op; reqAddr = addr; reqData = data; reqBit = b;
        while (!reqReady && budget < 50) begin
            @(negedge clock);
            budget++;
        end
        if (!reqReady) begin
            checkOutput("accept_timeout", 32'(reqReady), 32'(1));
            reqValid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        acc   = cyc;
        byteA = {addr[7:3], 3'b000};
        idx   = addr[2:0];
        e.op = op; e.err = 1'b0; e.chkData = 1'b0; e.data = 8'h00;
        e.chkBit = 1'b0; e.bitv = 1'b0; e.chkAddr = 1'b1; e.addr = addr;
        w.isBit = 1'b0; w.addr = addr; w.wdata = 8'h00; w.bitv = 1'b0;
        lat = 1;
        if (!addr[7]) begin
            e.err = 1'b1; e.chkData = 1'b1; e.data = 8'h00; e.chkAddr = 1'b0;
            lat = 1;
        end else begin
            case (op)
                3'd0: begin
                    e.chkData = 1'b1; e.data = model[addr]; lat = LAT + 1;
                end
                3'd1: begin
                    model[addr] = data; w.wdata = data; wrQ.push_back(w);
                    e.chkData = 1'b1; e.data = data; lat = 2;
                end
                3'd2: begin
                    e.chkData = 1'b1; e.data = model[byteA];
                    e.chkBit = 1'b1; e.bitv = model[byteA][idx];
                    e.addr = byteA; lat = LAT + 1;
                end
                3'd3: begin
                    model[byteA][idx] = b; w.isBit = 1'b1; w.bitv = b; wrQ.push_back(w);
                    lat = 2;
                end
                3'd7: begin
                    nb = ~model[byteA][idx]; model[byteA][idx] = nb;
                    w.isBit = 1'b1; w.bitv = nb; wrQ.push_back(w);
                    e.chkBit = 1'b1; e.bitv = nb; lat = LAT + 3;
                end
                default: begin
                    if (op == 3'd4)      nv = model[addr] & data;
                    else if (op == 3'd5) nv = model[addr] | data;
                    else                 nv = model[addr] ^ data;
                    model[addr] = nv; w.wdata = nv; wrQ.push_back(w);
                    e.chkData = 1'b1; e.data = nv; lat = LAT + 3;
                end
            endcase
        end
        e.due = acc + lat - 1;
        rspQ.push_back(e);
        if (!hold) begin
            reqValid = 1'b0;
            reqOp = 3'($urandom); reqAddr = 8'($urandom); reqData = 8'($urandom); reqBit = 1'($urandom);
        end
    endtask

    task automatic waitIdle();
        int budget = 0;
        while (rspQ.size() > 0 && budget < 200) begin
            @(negedge clock);
            budget++;
        end
        checkOutput("drain_pending_rsp", 32'(rspQ.size()), 32'(0));
    endtask

    task automatic applyStimulus2(input logic [2:0] op, input logic [7:0] addr,
                                  input logic [7:0] data, output int acc);
        int budget = 0;
        acc = -1;
        @(negedge clock);
        reqValid2 = 1'b1; reqOp2 = op; reqAddr2 = addr; reqData2 = data;
        while (!reqReady2 && budget < 20) begin
            @(negedge clock);
            budget++;
        end
        if (!reqReady2) begin
            checkOutput("dut2_accept_timeout", 32'(reqReady2), 32'(1));
            reqValid2 = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        acc = cyc;
        reqValid2 = 1'b0;
        reqAddr2 = 8'($urandom); reqData2 = 8'($urandom);
    endtask

    task automatic waitRsp2(output int seen);
        seen = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (rspValid2) begin
                seen = cyc;
                break;
            end
        end
    endtask

    // Monitor for the main instance: bus writes and responses are popped from
    // their queues in order and compared when the DUT presents them.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (sfrWriteEn || sfrWriteBitEn) begin
                    checkOutput("strobe_exclusive", 32'(sfrWriteEn & sfrWriteBitEn), 32'(0));
                    if (wrQ.size() == 0) begin
                        checkOutput("unexpected_write", 32'({sfrWriteBitEn, sfrWriteEn}), 32'(0));
                    end else begin
                        monW = wrQ.pop_front();
                        checkOutput("write_kind", 32'({sfrWriteBitEn, sfrWriteEn}), monW.isBit ? 32'(2) : 32'(1));
                        checkOutput("write_addr", 32'(sfrAddr), 32'(monW.addr));
                        if (monW.isBit) checkOutput("write_bit", 32'(sfrBit), 32'(monW.bitv));
                        else            checkOutput("write_data", 32'(sfrWdata), 32'(monW.wdata));
                    end
                end
                if (rspValid) begin
                    if (rspQ.size() == 0) begin
                        checkOutput("unexpected_rsp", 32'(rspValid), 32'(0));
                    end else begin
                        monR = rspQ.pop_front();
                        checkOutput($sformatf("rsp_cycle op%0d", monR.op), 32'(cyc), 32'(monR.due));
                        checkOutput($sformatf("rsp_err op%0d", monR.op), 32'(rspErr), 32'(monR.err));
                        if (monR.chkData) checkOutput($sformatf("rsp_data op%0d", monR.op), 32'(rspData), 32'(monR.data));
                        if (monR.chkBit)  checkOutput($sformatf("rsp_bit op%0d", monR.op), 32'(rspBit), 32'(monR.bitv));
                        if (monR.chkAddr) checkOutput($sformatf("rsp_addr op%0d", monR.op), 32'(sfrAddr), 32'(monR.addr));
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] v;
        int acc;
        int seen;
        int mism;
        logic sawStrobe;
        logic sawRsp;

        reset = 1'b1; reqValid = 1'b0; reqOp = 3'd0; reqAddr = 8'h00; reqData = 8'h00; reqBit = 1'b0;
        reset2 = 1'b1; reqValid2 = 1'b0; reqOp2 = 3'd0; reqAddr2 = 8'h00; reqData2 = 8'h00;
        preEn = 1'b0; preAddr = 8'h00; preVal = 8'h00;

        for (int a = 0; a < 256; a++) begin
            v = 8'($urandom);
            case (a)
                8'hE0:   v = 8'h5A;
                8'hD0:   v = 8'h80;
                8'h80:   v = 8'h00;
                8'h90:   v = 8'hF0;
                8'hB0:   v = 8'h33;
                default: ;
            endcase
            model[a] = v;
            @(negedge clock);
            preEn = 1'b1; preAddr = 8'(a); preVal = v;
        end
        @(negedge clock);
        preEn = 1'b0;
        @(negedge clock);

        checkOutput("reset_req_ready", 32'(reqReady), 32'(1));
        checkOutput("reset_rsp_valid", 32'(rspValid), 32'(0));
        checkOutput("reset_rsp_fields", 32'({rspData, rspBit, rspErr}), 32'(0));
        checkOutput("reset_sfr_bus", 32'({sfrAddr, sfrWdata, sfrBit, sfrWriteEn, sfrWriteBitEn}), 32'(0));
        reset = 1'b0;

        applyStimulus(3'd0, 8'hE0, 8'h00, 1'b0, 1'b0);
        waitIdle();
        repeat (2) @(negedge clock);
        checkOutput("rsp_valid_single_pulse", 32'(rspValid), 32'(0));
        checkOutput("rsp_data_hold", 32'(rspData), 32'(8'h5A));

        applyStimulus(3'd1, 8'hF0, 8'h3C, 1'b0, 1'b0);
        applyStimulus(3'd0, 8'hF0, 8'h00, 1'b0, 1'b0);
        applyStimulus(3'd2, 8'hD7, 8'h00, 1'b0, 1'b0);
        applyStimulus(3'd3, 8'h85, 8'h00, 1'b1, 1'b0);
        applyStimulus(3'd0, 8'h80, 8'h00, 1'b0, 1'b0);
        applyStimulus(3'd5, 8'h90, 8'h0F, 1'b0, 1'b0);
        applyStimulus(3'd1, 8'hE0, 8'h08, 1'b0, 1'b0);
        applyStimulus(3'd7, 8'hE3, 8'h00, 1'b0, 1'b0);
        applyStimulus(3'd0, 8'hE0, 8'h00, 1'b0, 1'b0);
        applyStimulus(3'd0, 8'h30, 8'h00, 1'b0, 1'b0);
        waitIdle();

        // Back-to-back requests with req_valid held high between them.
        for (int i = 0; i < 8; i++)
            applyStimulus(3'(i), 8'hE0 + 8'(i), 8'($urandom), 1'($urandom), 1'b1);
        reqValid = 1'b0;
        waitIdle();

        for (int i = 0; i < 80; i++) begin
            v = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 127)) : 8'($urandom_range(128, 255));
            applyStimulus(3'($urandom_range(0, 7)), v, 8'($urandom), 1'($urandom), 1'($urandom));
        end
        reqValid = 1'b0;
        waitIdle();
        repeat (3) @(negedge clock);
        checkOutput("pending_writes", 32'(wrQ.size()), 32'(0));

        mism = 0;
        for (int a = 128; a < 256; a++)
            if (regs[a] !== model[a]) mism++;
        checkOutput("final_sfr_image_mismatches", 32'(mism), 32'(0));

        // RD_LATENCY=2 instance: read timing, then reset during XRL WAIT.
        @(negedge clock);
        reset2 = 1'b0;
        @(negedge clock);
        checkOutput("lat2_ready_after_reset", 32'(reqReady2), 32'(1));

        applyStimulus2(3'd0, 8'hE0, 8'h00, acc);
        waitRsp2(seen);
        checkOutput("lat2_rd_cycle", 32'(seen), 32'(acc + 2));
        checkOutput("lat2_rd_data", 32'(rspData2), 32'(8'h5A));
        checkOutput("lat2_rd_err", 32'(rspErr2), 32'(0));

        applyStimulus2(3'd2, 8'hE6, 8'h00, acc);
        waitRsp2(seen);
        checkOutput("lat2_brd_cycle", 32'(seen), 32'(acc + 2));
        checkOutput("lat2_brd_bit", 32'(rspBit2), 32'(1));

        applyStimulus2(3'd6, 8'hB0, 8'hFF, acc);
        sawStrobe = 1'b0;
        sawRsp    = 1'b0;
        @(negedge clock);
        sawStrobe |= sfrWriteEn2 | sfrWriteBitEn2;
        sawRsp    |= rspValid2;
        @(negedge clock);
        sawStrobe |= sfrWriteEn2 | sfrWriteBitEn2;
        sawRsp    |= rspValid2;
        reset2 = 1'b1;
        @(negedge clock);
        reset2 = 1'b0;
        checkOutput("xrl_reset_strobes_low", 32'({sfrWriteEn2, sfrWriteBitEn2}), 32'(0));
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            sawStrobe |= sfrWriteEn2 | sfrWriteBitEn2;
            sawRsp    |= rspValid2;
            if (i == 0) checkOutput("xrl_reset_ready_next", 32'(reqReady2), 32'(1));
        end
        checkOutput("xrl_reset_no_strobe", 32'(sawStrobe), 32'(0));
        checkOutput("xrl_reset_no_rsp", 32'(sawRsp), 32'(0));
        checkOutput("xrl_reset_target_unchanged", 32'(regs2[8'hB0]), 32'(8'h33));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
